serial_tx_fifo: RTL and testbench
=================================

// Module: serial_tx_fifo
// PURPOSE
//  Parametrised successor to the fixed-width transmitter: async-style serial frame generator
//  (start, DATA_W data bits LSB-first, optional parity, STOP_BITS stop bits) with built-in FIFO.
//  Bit timing comes from an internal divider on the single system clock; no external major/minor clocks.
//  Sits between the processor PIO (data_bus/load/transmit_enable) and the GPIO serial pin.
// PARAMETERS
//  DATA_W        8    data bits per frame (5..16)
//  FIFO_DEPTH    4    FIFO entries, power of two (2..64)
//  CLKS_PER_BIT  2048 clk cycles per serial bit (>=2)
//  STOP_BITS     1    stop bits per frame (1 or 2)
// PORTS
//  clk              in   1                 system clock; all logic on posedge
//  rst              in   1                 synchronous, active-high reset
//  data_in          in   DATA_W            character to enqueue
//  load             in   1                 write strobe; data_in pushed when load && !full
//  transmit_enable  in   1                 1 = frames may start; 0 = hold queued data
//  data_out         out  1                 serial line, idle high
//  character_sent   out  1                 1-cycle pulse at end of each frame's last stop bit
//  busy             out  1                 1 while a frame is on the line (state != IDLE)
//  full             out  1                 FIFO count == FIFO_DEPTH
//  empty            out  1                 FIFO count == 0
//  fifo_count       out  $clog2(DEPTH)+1   entries held
//  overflow         out  1                 sticky: load seen while full; cleared by rst only
// BEHAVIOUR
//  Reset (sync, rst high at edge): data_out=1, character_sent=0, busy=0, full=0, empty=1,
//   fifo_count=0, overflow=0, FSM=IDLE, divider=0, FIFO pointers=0. Applies mid-frame: line
//   returns high next edge, partial frame abandoned, queued data discarded, no character_sent.
//  FIFO: circular, rd/wr pointers wrap modulo FIFO_DEPTH. Push when load&&!full; full evaluated
//   from pre-edge count, so load while full is dropped (sets overflow) even if a pop occurs same edge.
//   Simultaneous push and pop when neither full nor empty: count unchanged.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//   IDLE: data_out=1. If !empty && transmit_enable at edge: pop head into shift reg, -> START.
//   START: data_out=0 for CLKS_PER_BIT cycles. DATA: shift out bit0 first, DATA_W bits,
//   each CLKS_PER_BIT cycles. PARITY: one bit period (macro only). STOP: data_out=1 for
//   STOP_BITS*CLKS_PER_BIT cycles.
//   End of STOP: character_sent=1 for that final cycle; next state START directly (back-to-back,
//   no idle gap) if !empty && transmit_enable, else IDLE.
//  Latency: load at edge E into empty FIFO with transmit_enable=1 -> data_out falls after edge E+1.
//  Frame length: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 with parity else 0.
//  transmit_enable dropping mid-frame: current frame completes unchanged; no new frame starts.
//  Divider counts 0..CLKS_PER_BIT-1, resets to 0 on every state entry; no drift across frames.
//  data_in captured at push; later changes to data_in do not affect queued/active characters.
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined: PARITY state inserted after DATA; bit = even parity
//   (XOR of the DATA_W data bits), P=1.
//  Not defined: PARITY state and parity logic absent; DATA goes straight to STOP, P=0.
// TESTING  (DATA_W=8, FIFO_DEPTH=4, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1 Single char: rst 2 cycles, load 8'h74 one cycle, enable=1 -> data_out low after next edge;
//    line = 0,0,0,1,0,1,1,1,0,1 (4 clk each); character_sent pulse at cycle 40 of frame; busy 40 cycles.
//  2 Burst: load 74,65,73,74 on 4 consecutive cycles -> full=1 after 4th push until first pop;
//    4 frames back-to-back, no idle cycles, 4 character_sent pulses 40 cycles apart, then empty=1.
//  3 Overflow: enable=0, load 5 chars -> fifo_count=4, overflow=1, 5th char never transmitted;
//    raise enable -> first 4 sent in order.
//  4 Gate: drop transmit_enable at cycle 10 of frame 1 with 2 queued -> frame 1 completes, line
//    idle high, fifo_count=1; re-enable -> next frame starts one edge later.
//  5 Reset mid-frame: assert rst during DATA bit 3 -> data_out=1, count=0, no character_sent pulse.
//  6 SERIAL_TX_PARITY_EN: send 8'h74 (four 1s) -> parity bit 0; 8'h75 -> 1; frame 44 cycles.

Source files
------------

// File: rtl/serial_tx_fifo_if.sv
// Bundles the PIO-side handshake and the serial/status outputs of serial_tx_fifo.
// The master modport is the processor side and the slave modport is the transmitter.
interface serial_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              transmit_enable;
    logic              data_out;
    logic              character_sent;
    logic              busy;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport master (
        output data_in, load, transmit_enable,
        input  data_out, character_sent, busy, full, empty, fifo_count, overflow
    );

    modport slave (
        input  data_in, load, transmit_enable,
        output data_out, character_sent, busy, full, empty, fifo_count, overflow
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Async-style serial frame generator with a circular FIFO in front of it.
// Each frame is: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Bit timing comes from an internal divider on clk. The FIFO can hold FIFO_DEPTH characters.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit after the data bits.
module serial_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 2048,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_tx_fifo_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_tick, start_ok, tx_bit, char_sent;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // full/empty come from the pre-edge count, so a load while full is dropped even on a pop edge
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign push     = bus.load && !full;
    assign head     = mem_q[rd_ptr_q];
    assign bit_tick = (div_q == DIV_LAST);
    assign start_ok = !empty && bus.transmit_enable;

    // FIFO occupancy bookkeeping
    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO pointers, count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (bus.load && full) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    // Bit-period divider: restarts on every bit boundary and is held at zero while idle
    always_comb begin
        div_d = (state_q == ST_IDLE || bit_tick) ? '0 : div_q + DIV_W'(1);
    end

    // Frame sequencing, FIFO pop and line level
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        char_sent = 1'b0;
        tx_bit    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_bit = 1'b0;
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_bit = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                tx_bit = parity_q;
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_bit = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        char_sent = 1'b1;
                        bit_cnt_d = '0;
                        // back-to-back frames skip IDLE entirely
                        if (start_ok) begin
                            pop     = 1'b1;
                            shift_d = head;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef SERIAL_TX_PARITY_EN
        // parity latched with the character because the shift register is consumed bit by bit
        if (pop) parity_d = ^head;
`endif
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.data_out       = tx_bit;
    assign bus.character_sent = char_sent;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Testbench for serial_tx_fifo: scenario tasks checked against a queue-based frame model.
module tb_serial_tx_fifo;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int CPB       = 4;
    localparam int STOP_BITS = 1;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + DATA_W + P + STOP_BITS) * CPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

    serial_tx_fifo #(
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending characters, and the remaining line samples of the frame in flight
    // (front = level expected during the current cycle).
    logic [DATA_W-1:0] m_fifo [$];
    logic              m_line [$];
    logic              m_ovf = 1'b0;

    task automatic push_frame(input logic [DATA_W-1:0] c);
        repeat (CPB) m_line.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) repeat (CPB) m_line.push_back(c[i]);
        if (P == 1) repeat (CPB) m_line.push_back(^c);
        repeat (STOP_BITS * CPB) m_line.push_back(1'b1);
    endtask

    task automatic model_edge(input logic r, input logic l, input logic [DATA_W-1:0] d,
                              input logic en);
        bit was_full;
        if (r) begin
            m_fifo.delete();
            m_line.delete();
            m_ovf = 1'b0;
            return;
        end
        was_full = (m_fifo.size() == DEPTH);
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (m_line.size() == 0 && m_fifo.size() > 0 && en) push_frame(m_fifo.pop_front());
        if (l) begin
            if (was_full) m_ovf = 1'b1;
            else m_fifo.push_back(d);
        end
    endtask

    function automatic logic e_dout();
        return (m_line.size() > 0) ? m_line[0] : 1'b1;
    endfunction
    function automatic logic e_sent();
        return (m_line.size() == 1);
    endfunction
    function automatic logic e_busy();
        return (m_line.size() > 0);
    endfunction
    function automatic logic [CNT_W-1:0] e_cnt();
        return CNT_W'(m_fifo.size());
    endfunction

    // apply inputs for one edge, advance the model, then settle past the edge for sampling
    task automatic cycle(input logic r, input logic l, input logic [DATA_W-1:0] d, input logic en);
        rst = r;
        bus.load = l;
        bus.data_in = d;
        bus.transmit_enable = en;
        @(posedge clk);
        model_edge(r, l, d, en);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b1);
        vectors += 7;
        if (bus.data_out !== 1'b1) begin miscompares++; $display("FAIL reset_data_out: got %0b expected 1", bus.data_out); end
        if (bus.character_sent !== 1'b0) begin miscompares++; $display("FAIL reset_char_sent: got %0b expected 0", bus.character_sent); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b expected 0", bus.full); end
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0b expected 1", bus.empty); end
        if (bus.fifo_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow); end
    endtask

    task automatic test_single(input logic [DATA_W-1:0] c);
        int pulses = 0, pulse_at = -1, busy_cnt = 0;
        cycle(1'b0, 1'b1, c, 1'b1);
        vectors++;
        if (bus.data_out !== 1'b1 || bus.fifo_count !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL single_after_load: got line %0b count %0d expected line 1 count 1", bus.data_out, bus.fifo_count);
        end
        for (int k = 1; k <= FRAME + 4; k++) begin
            cycle(1'b0, 1'b0, DATA_W'($urandom()), 1'b1);
            vectors++;
            if (bus.data_out !== e_dout() || bus.character_sent !== e_sent()) begin
                miscompares++;
                $display("FAIL single_line cyc %0d: got line %0b sent %0b expected line %0b sent %0b",
                         k, bus.data_out, bus.character_sent, e_dout(), e_sent());
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.character_sent === 1'b1) begin pulses++; pulse_at = k; end
        end
        vectors += 3;
        if (pulses != 1) begin miscompares++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        if (pulse_at != FRAME) begin miscompares++; $display("FAIL single_pulse_pos: got %0d expected %0d", pulse_at, FRAME); end
        if (busy_cnt != FRAME) begin miscompares++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, FRAME); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, last = -1;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b0);
        vectors += 2;
        if (bus.full !== 1'b1) begin miscompares++; $display("FAIL burst_full: got %0b expected 1", bus.full); end
        if (bus.fifo_count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL burst_count: got %0d expected %0d", bus.fifo_count, DEPTH); end
        for (int k = 1; k <= DEPTH * FRAME + 6; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (bus.data_out !== e_dout() || bus.character_sent !== e_sent() ||
                bus.full !== (e_cnt() == CNT_W'(DEPTH)) || bus.empty !== (e_cnt() == '0)) begin
                miscompares++;
                $display("FAIL burst_cyc %0d: got line %0b sent %0b full %0b empty %0b expected line %0b sent %0b count %0d",
                         k, bus.data_out, bus.character_sent, bus.full, bus.empty, e_dout(), e_sent(), e_cnt());
            end
            if (bus.character_sent === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (k - last != FRAME) begin miscompares++; $display("FAIL burst_gap: got %0d expected %0d", k - last, FRAME); end
                end
                pulses++;
                last = k;
            end
        end
        vectors += 2;
        if (pulses != DEPTH) begin miscompares++; $display("FAIL burst_pulses: got %0d expected %0d", pulses, DEPTH); end
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL burst_empty_end: got %0b expected 1", bus.empty); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b0);
        vectors += 2;
        if (bus.fifo_count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL ovf_count: got %0d expected %0d", bus.fifo_count, DEPTH); end
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow); end
        for (int k = 1; k <= (DEPTH + 1) * FRAME + 4; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (bus.data_out !== e_dout() || bus.overflow !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_drain cyc %0d: got line %0b ovf %0b expected line %0b ovf 1", k, bus.data_out, bus.overflow, e_dout());
            end
            if (bus.character_sent === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != DEPTH) begin miscompares++; $display("FAIL ovf_pulses: got %0d expected %0d", pulses, DEPTH); end
    endtask

    task automatic test_gate();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b1);
        cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b1);
        for (int k = 2; k <= 9; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        for (int k = 10; k <= FRAME + 5; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            vectors++;
            if (bus.data_out !== e_dout() || bus.busy !== e_busy()) begin
                miscompares++;
                $display("FAIL gate_frame cyc %0d: got line %0b busy %0b expected line %0b busy %0b", k, bus.data_out, bus.busy, e_dout(), e_busy());
            end
        end
        vectors += 3;
        if (bus.fifo_count !== CNT_W'(1)) begin miscompares++; $display("FAIL gate_count: got %0d expected 1", bus.fifo_count); end
        if (bus.data_out !== 1'b1) begin miscompares++; $display("FAIL gate_idle_line: got %0b expected 1", bus.data_out); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL gate_idle_busy: got %0b expected 0", bus.busy); end
        cycle(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.data_out !== 1'b0) begin miscompares++; $display("FAIL gate_restart: got %0b expected 0", bus.data_out); end
        for (int k = 1; k <= FRAME + 2; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (bus.data_out !== e_dout()) begin miscompares++; $display("FAIL gate_second cyc %0d: got %0b expected %0b", k, bus.data_out, e_dout()); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses = 0;
        cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b1);
        cycle(1'b0, 1'b1, DATA_W'($urandom()), 1'b1);
        // land inside the fourth data bit (index 3)
        for (int k = 2; k <= CPB + 3 * CPB + 2; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        vectors += 4;
        if (bus.data_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_line: got %0b expected 1", bus.data_out); end
        if (bus.fifo_count !== '0) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 0", bus.fifo_count); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %0b expected 0", bus.busy); end
        if (bus.character_sent !== 1'b0) begin miscompares++; $display("FAIL rstmid_sent: got %0b expected 0", bus.character_sent); end
        for (int k = 1; k <= FRAME; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (bus.character_sent === 1'b1) pulses++;
            vectors++;
            if (bus.data_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_after cyc %0d: got %0b expected 1", k, bus.data_out); end
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_random();
        logic en = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) < 4) en = ~en;
            cycle(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 20), DATA_W'($urandom()), en);
            vectors++;
            if (bus.data_out !== e_dout() || bus.character_sent !== e_sent() || bus.busy !== e_busy() ||
                bus.fifo_count !== e_cnt() || bus.full !== (e_cnt() == CNT_W'(DEPTH)) ||
                bus.empty !== (e_cnt() == '0) || bus.overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL random cyc %0d: got line %0b sent %0b busy %0b count %0d ovf %0b expected line %0b sent %0b busy %0b count %0d ovf %0b",
                         k, bus.data_out, bus.character_sent, bus.busy, bus.fifo_count, bus.overflow,
                         e_dout(), e_sent(), e_busy(), e_cnt(), m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0;
        bus.data_in = '0;
        bus.transmit_enable = 1'b0;
        test_reset();
        test_single(8'h74);
        test_single(8'h75);
        test_back_to_back();
        test_overflow();
        test_gate();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
